// File: rtl/sram_arb_pkg.sv
// Shared definitions for the cartridge SRAM arbiter: FSM states, requester ids and access-length limits.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PORT_SNES = 2'd0,
    PORT_MCU  = 2'd1,
    PORT_DMA  = 2'd2
  } port_t;

  localparam int CYCLE_LEN_MIN = 3;
  localparam int CYCLE_LEN_MAX = 15;
  localparam int CNT_W         = 4;

  // One-hot mask of a requester id, bit order {dma, mcu, snes}.
  function automatic logic [2:0] port_mask(input port_t p);
    logic [2:0] m;
    case (p)
      PORT_SNES: m = 3'b001;
      PORT_MCU:  m = 3'b010;
      PORT_DMA:  m = 3'b100;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational picker: SNES fixed priority, MCU/DMA round-robin on rr (0 = MCU first).
// The DMA leg exists only when SRAM_ARB_DMA_EN is defined.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       rr,
  input  logic       excl_en,
  input  port_t      excl_id,
  output port_t      gnt,
  output logic       valid
);

  logic [2:0] elig_s;

  // Drop the just-served port, then resolve priority.
  always_comb begin
    gnt   = PORT_SNES;
    valid = 1'b0;
    if (excl_en) begin
      elig_s = req & ~port_mask(excl_id);
    end else begin
      elig_s = req;
    end
    if (elig_s[0]) begin
      gnt   = PORT_SNES;
      valid = 1'b1;
`ifdef SRAM_ARB_DMA_EN
    end else if (elig_s[1] && elig_s[2]) begin
      gnt   = rr ? PORT_DMA : PORT_MCU;
      valid = 1'b1;
    end else if (elig_s[1]) begin
      gnt   = PORT_MCU;
      valid = 1'b1;
    end else if (elig_s[2]) begin
      gnt   = PORT_DMA;
      valid = 1'b1;
`else
    end else if (elig_s[1]) begin
      gnt   = PORT_MCU;
      valid = 1'b1;
`endif
    end else begin
      gnt   = PORT_SNES;
      valid = 1'b0;
    end
  end

`ifndef SRAM_ARB_DMA_EN
  logic unused_pick_s;
  assign unused_pick_s = rr ^ elig_s[2];
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the shared cartridge SRAM/ROM bus with fixed strobe timing per access.
// Define SRAM_ARB_DMA_EN to let the DMA1 port take part in arbitration.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int CYCLE_LEN = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              snes_we,
  input  logic [DATA_W-1:0] snes_wdata,
  output logic              snes_ack,
  output logic [DATA_W-1:0] snes_rdata,
  input  logic              mcu_req,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic              mcu_we,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic              mcu_ack,
  output logic [DATA_W-1:0] mcu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [DATA_W-1:0] ROM_DATA_O,
  output logic              ROM_DATA_OE,
  input  logic [DATA_W-1:0] ROM_DATA_I,
  output logic              ROM_WE_n,
  output logic              ROM_OE_n,
  output logic              ROM_BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_LEN - 1);
  localparam logic [CNT_W-1:0] WE_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(CYCLE_LEN - 2);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  port_t             gnt_r, pick_gnt_s;
  logic              pick_valid_s, we_r, we_s, start_s, done_edge_s, acc_s, rr_s;
  logic [2:0]        req_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_wdata_s;

`ifdef SRAM_ARB_DMA_EN
  logic rr_r;
  assign req_s = {dma_req, mcu_req, snes_req};
  assign rr_s  = rr_r;
`else
  logic unused_dma_s;
  assign req_s        = {1'b0, mcu_req, snes_req};
  assign rr_s         = 1'b0;
  assign unused_dma_s = ^{dma_req, dma_we, dma_addr, dma_wdata};
  assign dma_ack      = 1'b0;
  assign dma_rdata    = {DATA_W{1'b0}};
`endif

  sram_arb_pick u_pick (
    .req     (req_s),
    .rr      (rr_s),
    .excl_en (state_r == ST_DONE),
    .excl_id (gnt_r),
    .gnt     (pick_gnt_s),
    .valid   (pick_valid_s)
  );

  // Route the winning requester's transaction fields.
  always_comb begin
    sel_addr_s  = snes_addr;
    sel_we_s    = snes_we;
    sel_wdata_s = snes_wdata;
    case (pick_gnt_s)
      PORT_SNES: begin
        sel_addr_s  = snes_addr;
        sel_we_s    = snes_we;
        sel_wdata_s = snes_wdata;
      end
      PORT_MCU: begin
        sel_addr_s  = mcu_addr;
        sel_we_s    = mcu_we;
        sel_wdata_s = mcu_wdata;
      end
`ifdef SRAM_ARB_DMA_EN
      PORT_DMA: begin
        sel_addr_s  = dma_addr;
        sel_we_s    = dma_we;
        sel_wdata_s = dma_wdata;
      end
`endif
      default: begin
        sel_addr_s  = snes_addr;
        sel_we_s    = snes_we;
        sel_wdata_s = snes_wdata;
      end
    endcase
  end

  // Next-state and access counter; a new grant may start from IDLE or straight out of DONE.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    start_s     = 1'b0;
    done_edge_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (pick_valid_s) begin
          state_s = ST_ACCESS;
          cnt_s   = {CNT_W{1'b0}};
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_LAST) begin
          state_s     = ST_DONE;
          cnt_s       = {CNT_W{1'b0}};
          done_edge_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
    we_s  = start_s ? sel_we_s : we_r;
    acc_s = (state_s == ST_ACCESS);
  end

  // FSM state, grant latch and bus strobes, all registered from next-cycle values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      gnt_r       <= PORT_SNES;
      we_r        <= 1'b0;
      ROM_ADDR    <= {ADDR_W{1'b0}};
      ROM_DATA_O  <= {DATA_W{1'b0}};
      ROM_DATA_OE <= 1'b0;
      ROM_WE_n    <= 1'b1;
      ROM_OE_n    <= 1'b1;
      ROM_BUSY    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (start_s) begin
        gnt_r      <= pick_gnt_s;
        we_r       <= sel_we_s;
        ROM_ADDR   <= sel_addr_s;
        ROM_DATA_O <= sel_wdata_s;
      end
      ROM_BUSY    <= (state_s != ST_IDLE);
      ROM_OE_n    <= ~(acc_s & ~we_s);
      ROM_DATA_OE <= acc_s & we_s;
      // Write strobe is inset by one cycle at each end for address/data setup and hold.
      ROM_WE_n    <= ~(acc_s & we_s & (cnt_s >= WE_FIRST) & (cnt_s <= WE_LAST));
    end
  end

`ifdef SRAM_ARB_DMA_EN
  // Round-robin pointer flips away from whichever of MCU/DMA was just granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_r <= 1'b0;
    end else if (start_s && (pick_gnt_s != PORT_SNES)) begin
      rr_r <= (pick_gnt_s == PORT_MCU);
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

  // Completion pulse and read-data capture at the last ACCESS edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snes_ack   <= 1'b0;
      mcu_ack    <= 1'b0;
      snes_rdata <= {DATA_W{1'b0}};
      mcu_rdata  <= {DATA_W{1'b0}};
`ifdef SRAM_ARB_DMA_EN
      dma_ack    <= 1'b0;
      dma_rdata  <= {DATA_W{1'b0}};
`endif
    end else begin
      snes_ack <= done_edge_s && (gnt_r == PORT_SNES);
      mcu_ack  <= done_edge_s && (gnt_r == PORT_MCU);
`ifdef SRAM_ARB_DMA_EN
      dma_ack  <= done_edge_s && (gnt_r == PORT_DMA);
`endif
      if (done_edge_s && !we_r) begin
        case (gnt_r)
          PORT_SNES: snes_rdata <= ROM_DATA_I;
          PORT_MCU:  mcu_rdata  <= ROM_DATA_I;
`ifdef SRAM_ARB_DMA_EN
          PORT_DMA:  dma_rdata  <= ROM_DATA_I;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
